// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer that owns HI/LO and stalls D while busy.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled with `define MDU_MADD_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
`ifdef MDU_MADD_EN
  input  logic [3:0]  op,
`else
  input  logic [2:0]  op,
`endif
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out
);

`ifdef MDU_MADD_EN
  localparam int unsigned OpW = 4;
`else
  localparam int unsigned OpW = 3;
`endif

  localparam logic [OpW-1:0] OpMult  = OpW'(0);
  localparam logic [OpW-1:0] OpMultu = OpW'(1);
  localparam logic [OpW-1:0] OpDiv   = OpW'(2);
  localparam logic [OpW-1:0] OpDivu  = OpW'(3);
  localparam logic [OpW-1:0] OpMfhi  = OpW'(4);
  localparam logic [OpW-1:0] OpMflo  = OpW'(5);
  localparam logic [OpW-1:0] OpMthi  = OpW'(6);
  localparam logic [OpW-1:0] OpMtlo  = OpW'(7);
`ifdef MDU_MADD_EN
  localparam logic [OpW-1:0] OpMadd  = OpW'(8);
  localparam logic [OpW-1:0] OpMaddu = OpW'(9);
  localparam logic [OpW-1:0] OpMsub  = OpW'(10);
  localparam logic [OpW-1:0] OpMsubu = OpW'(11);
`endif

  localparam logic [4:0] MultCnt = 5'(MULT_CYCLES);
  localparam logic [4:0] DivCnt  = 5'(DIV_CYCLES);

  typedef enum logic {StIdle, StRun} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [OpW-1:0]   op_q;
  logic [31:0]      a_q, b_q;

  logic             is_mul, is_div;
  logic [63:0]      prod_s, prod_u, res;
  logic [31:0]      abs_a, abs_b, uq, ur, quo_s, rem_s;
  logic             commit_en;

  always_comb begin
    is_mul = (op == OpMult) || (op == OpMultu);
`ifdef MDU_MADD_EN
    is_mul = is_mul || ((op >= OpMadd) && (op <= OpMsubu));
`endif
    is_div = (op == OpDiv) || (op == OpDivu);
  end

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide on magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign abs_a = a_q[31] ? (~a_q + 32'd1) : a_q;
  assign abs_b = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign uq    = abs_a / abs_b;
  assign ur    = abs_a % abs_b;
  assign quo_s = (a_q[31] ^ b_q[31]) ? (~uq + 32'd1) : uq;
  assign rem_s = a_q[31] ? (~ur + 32'd1) : ur;

  always_comb begin
    res = {hi, lo};
    case (op_q)
      OpMult:  res = prod_s;
      OpMultu: res = prod_u;
      OpDiv:   res = {rem_s, quo_s};
      OpDivu:  res = {a_q % b_q, a_q / b_q};
`ifdef MDU_MADD_EN
      OpMadd:  res = {hi, lo} + prod_s;
      OpMaddu: res = {hi, lo} + prod_u;
      OpMsub:  res = {hi, lo} - prod_s;
      OpMsubu: res = {hi, lo} - prod_u;
`endif
      default: res = {hi, lo};
    endcase
  end

  assign commit_en = !(((op_q == OpDiv) || (op_q == OpDivu)) && (b_q == 32'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= 5'd0;
      op_q  <= '0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            if (is_mul || is_div) begin
              op_q  <= op;
              a_q   <= rs_val;
              b_q   <= rt_val;
              cnt   <= is_mul ? MultCnt : DivCnt;
              state <= StRun;
            end else if (op == OpMthi) begin
              hi <= rs_val;
            end else if (op == OpMtlo) begin
              lo <= rs_val;
            end
          end
        end
        StRun: begin
          if (cnt == 5'd1) begin
            cnt   <= 5'd0;
            state <= StIdle;
            if (commit_en) begin
              hi <= res[63:32];
              lo <= res[31:0];
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy     = (state == StRun);
  assign md_stall = d_is_md & (busy | (start & (is_mul | is_div)));
  assign mf_out   = (op == OpMfhi) ? hi : ((op == OpMflo) ? lo : 32'd0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && start && busy)
      $display("mdu_ctrl: warning: start ignored while busy (op=%0d)", op);
  end
`endif

endmodule
